// File: rtl/conv_1st_pkg.sv
// Shared constants, state codes and word packers for the first-layer
// convolution frame sequencer.
package conv_1st_pkg;

  localparam int DEF_PIX_WORDS  = 75;
  localparam int DEF_BIAS_WORDS = 34;

  localparam int SCAN_PTR_W = 7;
  localparam int BIAS_PTR_W = 6;
  localparam int SCAN_W     = 32 + 1 + SCAN_PTR_W;
  localparam int BIAS_W     = 16 + 2 + BIAS_PTR_W;

  // Pointer values that address no buffer entry, so the buffers hold.
  localparam logic [SCAN_PTR_W-1:0] SCAN_PTR_IDLE = 7'h7F;
  localparam logic [BIAS_PTR_W-1:0] BIAS_PTR_IDLE = 6'h3F;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_PIX  = 3'd1;
  localparam logic [2:0] ST_LOAD_BIAS = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_DRAIN     = 3'd6;

  typedef logic [SCAN_W-1:0] scan_word_t;
  typedef logic [BIAS_W-1:0] bias_word_t;

  function automatic scan_word_t pack_scan(input logic [31:0] data,
                                           input logic [SCAN_PTR_W-1:0] ptr);
    return {data, 1'b0, ptr};
  endfunction

  function automatic bias_word_t pack_bias(input logic [15:0] data,
                                           input logic [BIAS_PTR_W-1:0] ptr);
    return {data, 2'b00, ptr};
  endfunction

endpackage

// File: rtl/conv_1st_wdog.sv
// RUN-phase watchdog: reloads on kick, counts down while enabled and flags
// the cycle whose closing edge completes TIMEOUT idle cycles.
module conv_1st_wdog #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CW'(TIMEOUT);
    end else if (kick) begin
      r_count <= CW'(TIMEOUT);
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign expire = en & ~kick & (r_count == CW'(1));

endmodule

// File: rtl/conv_1st_sched.sv
// Frame sequencer: streams pixel and bias words into the conv block buffers,
// starts the block, counts result beats and reports done or error.
module conv_1st_sched
  import conv_1st_pkg::*;
#(
  parameter int PIX_WORDS  = DEF_PIX_WORDS,
  parameter int BIAS_WORDS = DEF_BIAS_WORDS,
  parameter int OUT_BEATS  = 32,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic [39:0] scan_o,
  output logic [23:0] bias_o,
  output logic        sta_o,
  input  logic        conv_valid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] frame_cnt_o
);

  localparam int LAST_IDX = PIX_WORDS + BIAS_WORDS - 1;
  localparam int BW       = $clog2(OUT_BEATS + 1);

  logic [2:0]    r_state, w_nstate;
  logic [6:0]    r_idx, w_nidx;
  logic [BW-1:0] r_beats, w_nbeats;
  logic [15:0]   r_frames, w_nframes;
  logic          r_ready, r_busy, r_sta, r_done, r_err;
  logic          w_sta, w_done, w_err;
  scan_word_t    r_scan, w_scan;
  bias_word_t    r_bias, w_bias;

  logic          w_accept, w_beat, w_kick, w_wd_en, w_expire;
  logic [BIAS_PTR_W-1:0] w_bptr;

  assign w_accept = s_valid & r_ready;
  assign w_beat   = (r_state == ST_RUN) & conv_valid_i;
  assign w_kick   = (r_state == ST_START) | w_beat;
  assign w_wd_en  = (r_state == ST_RUN);
  assign w_bptr   = BIAS_PTR_W'(r_idx - 7'(PIX_WORDS));

  conv_1st_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .kick   (w_kick),
    .en     (w_wd_en),
    .expire (w_expire)
  );

  always_comb begin
    w_nstate  = r_state;
    w_nidx    = r_idx;
    w_nbeats  = r_beats;
    w_nframes = r_frames;
    w_scan    = pack_scan(32'h0, SCAN_PTR_IDLE);
    w_bias    = pack_bias(16'h0, BIAS_PTR_IDLE);
    w_sta     = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD_PIX, ST_LOAD_BIAS: begin
        if (w_accept) begin
          if (r_idx < 7'(PIX_WORDS)) begin
            w_scan = pack_scan(s_data, r_idx);
          end else begin
            w_bias = pack_bias(s_data[15:0], w_bptr);
          end
          // Only the final frame word may carry s_last; anything else aborts.
          if (r_idx == 7'(LAST_IDX)) begin
            w_nidx = '0;
            if (s_last) begin
              w_nstate = ST_START;
              w_sta    = 1'b1;
            end else begin
              w_nstate = ST_DRAIN;
              w_err    = 1'b1;
            end
          end else if (s_last) begin
            w_nidx   = '0;
            w_nstate = ST_IDLE;
            w_err    = 1'b1;
          end else begin
            w_nidx   = r_idx + 7'd1;
            w_nstate = ((r_idx + 7'd1) < 7'(PIX_WORDS)) ? ST_LOAD_PIX : ST_LOAD_BIAS;
          end
        end
      end
      ST_START: begin
        w_nstate = ST_RUN;
        w_nbeats = '0;
      end
      ST_RUN: begin
        if (w_beat) begin
          if (r_beats == BW'(OUT_BEATS - 1)) begin
            w_nstate  = ST_DONE;
            w_done    = 1'b1;
            w_nframes = r_frames + 16'd1;
            w_nbeats  = '0;
          end else begin
            w_nbeats = r_beats + BW'(1);
          end
        end else if (w_expire) begin
          w_nstate = ST_IDLE;
          w_err    = 1'b1;
        end
      end
      ST_DONE: begin
        w_nstate = ST_IDLE;
      end
      ST_DRAIN: begin
        if (w_accept && s_last) begin
          w_nstate = ST_IDLE;
        end
      end
      default: begin
        w_nstate = ST_IDLE;
        w_nidx   = '0;
      end
    endcase
  end

  // Ready and busy are registered from the next state, never from s_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_beats  <= '0;
      r_frames <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_sta    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_scan   <= pack_scan(32'h0, SCAN_PTR_IDLE);
      r_bias   <= pack_bias(16'h0, BIAS_PTR_IDLE);
    end else begin
      r_state  <= w_nstate;
      r_idx    <= w_nidx;
      r_beats  <= w_nbeats;
      r_frames <= w_nframes;
      r_ready  <= (w_nstate == ST_IDLE) || (w_nstate == ST_LOAD_PIX) ||
                  (w_nstate == ST_LOAD_BIAS) || (w_nstate == ST_DRAIN);
      r_busy   <= (w_nstate != ST_IDLE);
      r_sta    <= w_sta;
      r_done   <= w_done;
      r_err    <= w_err;
      r_scan   <= w_scan;
      r_bias   <= w_bias;
    end
  end

  assign s_ready     = r_ready;
  assign busy_o      = r_busy;
  assign sta_o       = r_sta;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign scan_o      = r_scan;
  assign bias_o      = r_bias;
  assign frame_cnt_o = r_frames;

endmodule

// File: tb/tb_conv_1st_sched.sv
// Scenario bench for conv_1st_sched: a stream driver pushes expected buffer
// writes to queues and a negedge monitor pops and compares them.
module tb_conv_1st_sched;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        conv_valid_i = 1'b0;
  logic        s_ready;
  logic [39:0] scan_o;
  logic [23:0] bias_o;
  logic        sta_o, busy_o, done_o, err_o;
  logic [15:0] frame_cnt_o;

  int compared = 0;
  int mismatched = 0;
  int staCnt = 0, doneCnt = 0, errCnt = 0, scanIdleCnt = 0;
  int idleAtFirst = 0, idleAtLastPix = 0;

  logic [39:0] scanQ[$];
  logic [23:0] biasQ[$];
  logic [39:0] expScan;
  logic [23:0] expBias;

  always #5 clk = ~clk;

  conv_1st_sched #(
    .PIX_WORDS(75), .BIAS_WORDS(34), .OUT_BEATS(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .scan_o(scan_o), .bias_o(bias_o),
    .sta_o(sta_o), .conv_valid_i(conv_valid_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  // Monitor: every non-idle pointer must match the next queued expected write.
  always @(negedge clk) begin
    if (sta_o)  staCnt++;
    if (done_o) doneCnt++;
    if (err_o)  errCnt++;
    compared++;
    if (scan_o[6:0] != 7'h7F) begin
      if (scanQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL scan_unexpected got=%h required=none", scan_o);
      end else begin
        expScan = scanQ.pop_front();
        if (scan_o !== expScan) begin
          mismatched++;
          $display("[TB] FAIL scan_word got=%h required=%h", scan_o, expScan);
        end
      end
    end else begin
      scanIdleCnt++;
      if (scan_o[39:7] !== 33'h0) begin
        mismatched++;
        $display("[TB] FAIL scan_idle got=%h required=%h", scan_o, 40'h7F);
      end
    end
    compared++;
    if (bias_o[5:0] != 6'h3F) begin
      if (biasQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL bias_unexpected got=%h required=none", bias_o);
      end else begin
        expBias = biasQ.pop_front();
        if (bias_o !== expBias) begin
          mismatched++;
          $display("[TB] FAIL bias_word got=%h required=%h", bias_o, expBias);
        end
      end
    end else if (bias_o[23:6] !== 18'h0) begin
      mismatched++;
      $display("[TB] FAIL bias_idle got=%h required=%h", bias_o, 24'h3F);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  function automatic logic [31:0] wordData(input int k);
    if (k < 75) return 32'h03020100 + 32'(k) * 32'h04040404;
    return 32'(k - 75);
  endfunction

  task automatic send_word(input int k, input bit last);
    logic [31:0] d;
    bit rdy;
    int budget;
    d = wordData(k);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    rdy = 1'b0;
    budget = 0;
    while (!rdy && budget < 50) begin
      rdy = s_ready;
      @(posedge clk);
      if (!rdy) @(negedge clk);
      budget++;
    end
    if (!rdy) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout word=%0d got=not_accepted required=accepted", k);
    end else if (k < 75) begin
      scanQ.push_back({d, 1'b0, 7'(k)});
    end else if (k < 109) begin
      biasQ.push_back({d[15:0], 2'b00, 6'(k - 75)});
    end
  endtask

  task automatic stall_stream();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int nWords, input int lastAt, input bit throttle);
    for (int k = 0; k < nWords; k++) begin
      send_word(k, k == lastAt);
      if (k == 0)  idleAtFirst = scanIdleCnt;
      if (k == 74) idleAtLastPix = scanIdleCnt;
      if (throttle && k < nWords - 1) stall_stream();
    end
  endtask

  task automatic run_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      conv_valid_i = 1'b1;
    end
    @(negedge clk);
    conv_valid_i = 1'b0;
  endtask

  task automatic check_queues_empty(input string tag);
    compared++;
    if (scanQ.size() != 0 || biasQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_queues got=%0d/%0d required=0/0", tag, scanQ.size(), biasQ.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({s_ready, busy_o, sta_o, done_o, err_o} !== 5'b0 || frame_cnt_o !== 16'h0 ||
        scan_o !== 40'h7F || bias_o !== 24'h3F) begin
      mismatched++;
      $display("[TB] FAIL reset_values got=%b%b%b%b%b cnt=%h scan=%h bias=%h required=00000 0 7f 3f",
               s_ready, busy_o, sta_o, done_o, err_o, frame_cnt_o, scan_o, bias_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b1 || busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ready_after_reset got=%b/%b required=1/0", s_ready, busy_o);
    end
  endtask

  task automatic test_good_frame(input bit throttle, input logic [15:0] expFrames);
    int s0, d0, e0;
    s0 = staCnt; d0 = doneCnt; e0 = errCnt;
    send_frame(109, 108, throttle);
    stall_stream();
    compared++;
    if (sta_o !== 1'b1 || busy_o !== 1'b1 || s_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sta_rise got=%b/%b/%b required=1/1/0", sta_o, busy_o, s_ready);
    end
    compared++;
    if ((idleAtLastPix - idleAtFirst) != (throttle ? 74 : 0)) begin
      mismatched++;
      $display("[TB] FAIL pix_idle_gaps got=%0d required=%0d", idleAtLastPix - idleAtFirst, throttle ? 74 : 0);
    end
    run_beats(31);
    compared++;
    if (done_o !== 1'b0 || doneCnt != d0) begin
      mismatched++;
      $display("[TB] FAIL done_early got=%b required=0", done_o);
    end
    run_beats(1);
    compared++;
    if (done_o !== 1'b1 || frame_cnt_o !== expFrames) begin
      mismatched++;
      $display("[TB] FAIL done_pulse got=%b cnt=%0d required=1 cnt=%0d", done_o, frame_cnt_o, expFrames);
    end
    @(negedge clk);
    compared++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL back_to_idle got=%b/%b/%b required=0/0/1", done_o, busy_o, s_ready);
    end
    @(negedge clk);
    compared++;
    if (staCnt - s0 != 1 || doneCnt - d0 != 1 || errCnt != e0) begin
      mismatched++;
      $display("[TB] FAIL pulse_counts got=%0d/%0d/%0d required=1/1/0", staCnt - s0, doneCnt - d0, errCnt - e0);
    end
    check_queues_empty("good");
  endtask

  task automatic test_early_last();
    int s0, e0;
    s0 = staCnt; e0 = errCnt;
    send_frame(51, 50, 1'b0);
    stall_stream();
    compared++;
    if (err_o !== 1'b1 || sta_o !== 1'b0 || busy_o !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL early_last_err got=%b/%b/%b/%b required=1/0/0/1", err_o, sta_o, busy_o, s_ready);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (staCnt != s0 || errCnt - e0 != 1 || frame_cnt_o !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL early_last_counts got=sta%0d err%0d cnt%0d required=sta0 err1 cnt0",
               staCnt - s0, errCnt - e0, frame_cnt_o);
    end
    check_queues_empty("early");
  endtask

  task automatic test_missing_last();
    int s0, e0;
    s0 = staCnt; e0 = errCnt;
    send_frame(109, -1, 1'b0);
    stall_stream();
    compared++;
    if (err_o !== 1'b1 || busy_o !== 1'b1 || s_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL drain_enter got=%b/%b/%b required=1/1/1", err_o, busy_o, s_ready);
    end
    for (int k = 109; k <= 112; k++) send_word(k, k == 112);
    stall_stream();
    compared++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL drain_exit got=%b/%b/%b required=0/0/1", busy_o, err_o, s_ready);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (staCnt != s0 || errCnt - e0 != 1) begin
      mismatched++;
      $display("[TB] FAIL drain_counts got=sta%0d err%0d required=sta0 err1", staCnt - s0, errCnt - e0);
    end
    check_queues_empty("drain");
  endtask

  task automatic test_timeout(input logic [15:0] expFrames);
    int d0;
    bit early;
    d0 = doneCnt;
    send_frame(109, 108, 1'b0);
    stall_stream();
    run_beats(5);
    early = err_o;
    for (int n = 1; n < TO; n++) begin
      @(negedge clk);
      if (err_o) early = 1'b1;
    end
    compared++;
    if (early) begin
      mismatched++;
      $display("[TB] FAIL timeout_early got=err_before_%0d required=none", TO);
    end
    @(negedge clk);
    compared++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_err got=%b/%b required=1/0", err_o, busy_o);
    end
    conv_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    conv_valid_i = 1'b0;
    @(negedge clk);
    compared++;
    if (doneCnt != d0 || frame_cnt_o !== expFrames || busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_no_done got=done%0d cnt%0d busy%b required=done0 cnt%0d busy0",
               doneCnt - d0, frame_cnt_o, busy_o, expFrames);
    end
  endtask

  task automatic test_reset_in_run();
    send_frame(109, 108, 1'b0);
    stall_stream();
    run_beats(10);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({s_ready, busy_o, sta_o, done_o, err_o} !== 5'b0 || frame_cnt_o !== 16'h0 ||
        scan_o !== 40'h7F || bias_o !== 24'h3F) begin
      mismatched++;
      $display("[TB] FAIL reset_in_run got=%b%b%b%b%b cnt=%h required=00000 cnt=0",
               s_ready, busy_o, sta_o, done_o, err_o, frame_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_good_frame(1'b0, 16'd1);
  endtask

  initial begin
    $display("[TB] conv_1st_sched bench start");
    test_reset();
    test_early_last();
    test_good_frame(1'b0, 16'd1);
    test_good_frame(1'b1, 16'd2);
    test_missing_last();
    test_timeout(16'd2);
    test_reset_in_run();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_1st_sched.md
# conv_1st_sched

Frame sequencer for the first-layer convolution block. Accepts one frame as a valid/ready word stream: 75 packed-pixel words, then 34 bias/rescale words. It writes the stream into the convolution block's scan and bias buffers, issues the start pulse, counts result beats, and reports completion or error. It sits between the frame source (DMA/test host) and the convolution block's `scan_i`/`bias_i`/`sta`/`valid_o` pins.

## Interface
Parameters:
- `PIX_WORDS`, 75: pixel words per frame (4 pixels × 8 b each = 300 pixels).
- `BIAS_WORDS`, 34: bias entries per frame; index 32 = rescale multiplier, 33 = shift.
- `OUT_BEATS`, 32: `conv_valid_i` beats per frame.
- `TIMEOUT`, 4095: maximum idle cycles in RUN between start/beat and the next beat.

Ports (clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  stream word accepted when `s_valid & s_ready`
- `s_data`  in  32  stream word; bias phase uses `[15:0]`
- `s_last`  in  1  marks final word of frame
- `scan_o`  out  40  `{data[31:0], 1'b0, ptr[6:0]}` to conv block `scan_i`
- `bias_o`  out  24  `{data[15:0], 2'b0, ptr[5:0]}` to conv block `bias_i`
- `sta_o`  out  1  one-cycle start pulse
- `conv_valid_i`  in  1  conv block `valid_o`
- `busy_o`  out  1  high in any state except IDLE
- `done_o`  out  1  one-cycle pulse, frame complete
- `err_o`  out  1  one-cycle pulse, frame aborted
- `frame_cnt_o`  out  16  completed frames, wraps at 65535→0

## Operation
- States: IDLE, LOAD_PIX, LOAD_BIAS, START, RUN, DONE, DRAIN.
- IDLE: `s_ready`=1. First accepted word → LOAD_PIX behaviour for that word (word index 0).
- LOAD_PIX: accepted word k (0..74) drives `scan_o` = {s_data, 0, k}. After word 74 → LOAD_BIAS.
- LOAD_BIAS: accepted word j (0..33) drives `bias_o` = {s_data[15:0], 00, j}. Word 33 must carry `s_last`, then → START.
- Idle pointer values: `scan_o` ptr = 7'h7F and data = 0; `bias_o` ptr = 6'h3F and data = 0. These indices select no buffer entry, so buffers hold.
- `s_last` on any word other than frame word 108 → `err_o` pulse → IDLE; buffers keep the partial data and no `sta_o` is issued.
- Word 108 without `s_last` → `err_o` pulse → DRAIN. DRAIN: `s_ready`=1, words are discarded until an accepted word with `s_last`, then → IDLE.
- START: `sta_o`=1 for exactly one cycle → RUN.
- RUN: `s_ready`=0, so buffers are frozen during compute. Count `conv_valid_i` beats. Beat number `OUT_BEATS` → DONE.
- RUN timeout: the watchdog reloads on START and on each beat. If it reaches `TIMEOUT` cycles without a beat → `err_o` pulse → IDLE.
- DONE: `done_o`=1 for one cycle, `frame_cnt_o` increments → IDLE.
- `conv_valid_i` outside RUN is ignored.
- `s_valid` low mid-load stalls the FSM with no timeout and no pointer change.

## Timing
- All outputs are registered. A word accepted at edge N appears on `scan_o`/`bias_o` for cycle N..N+1 only, and the ptr returns to idle the next cycle unless another word is accepted. Back-to-back acceptance gives 1 word/cycle.
- `s_ready` is a registered function of state. It is never combinationally dependent on `s_valid`.
- `sta_o` rises the cycle after the edge that accepted word 108. Its first beat can be counted the cycle after `sta_o`.
- `done_o` rises the cycle after the edge sampling the final beat.
- Reset values: `s_ready`=0 while `rst_n` low and 1 after the first edge in IDLE; `scan_o`={32'h0,1'b0,7'h7F}; `bias_o`={16'h0,2'b0,6'h3F}; `sta_o`=`done_o`=`err_o`=`busy_o`=0; `frame_cnt_o`=0.
- Reset in any state → IDLE immediately, counters cleared, no pulses.

## Structure
- Package `conv_1st_pkg`: state enum, `PIX_WORDS`/`BIAS_WORDS` defaults, idle pointer constants 7'h7F / 6'h3F, scan/bias word field positions.
- Sub-module `conv_1st_wdog`: loadable down-counter of width $clog2(TIMEOUT+1) with `kick`, `en`, `expire` ports. It is used only in RUN.
- Word index counter: 7 bits, shared across pixel and bias phases; bias index = count − 75.

## Test plan
- Nominal frame: 109 back-to-back words (pixels 0x03020100+k·0x04040404, biases j) plus 32 beats → scan ptrs 0..74, bias ptrs 0..33 in order; `sta_o` one pulse; `done_o` one cycle after beat 32; `frame_cnt_o`=1.
- Throttled source: `s_valid` toggles 1/0 each cycle → identical ptr/data sequence, and the idle ptr (7'h7F) appears between words.
- Early `s_last` on word 50 → `err_o` pulse, no `sta_o`, back in IDLE; a following good frame completes with `frame_cnt_o`=1.
- Missing `s_last` on word 108, with `s_last` on extra word 112 → `err_o` at word 108, words 109–112 accepted and dropped, then IDLE.
- RUN with `TIMEOUT`=16 and only 5 beats → `err_o` 16 cycles after beat 5, `done_o` never asserted, `frame_cnt_o` unchanged.
- `rst_n` pulsed low during RUN after 10 beats → all outputs at reset values; a subsequent full frame requires all 32 new beats for `done_o`.
